// File: rtl/serial_addsub_pkg.sv
// Shared types for the digit-serial adder/subtractor: FSM states and mode encoding.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-bit ripple slice of the adder/subtractor; purely combinational.
module addsub_digit
  import serial_addsub_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             c_in,
  input  logic             a_ns,
  output logic [DIGIT-1:0] s,
  output logic             c_out
);

  logic [DIGIT:0] chain;

  // chain carries a carry when adding and a borrow when subtracting
  always_comb begin
    s        = '0;
    chain    = '0;
    chain[0] = c_in;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ chain[i];
      if (a_ns == MODE_ADD)
        chain[i+1] = (a[i] & b[i]) | (a[i] & chain[i]) | (b[i] & chain[i]);
      else
        chain[i+1] = (~a[i] & (b[i] | chain[i])) | (b[i] & chain[i]);
    end
  end

  assign c_out = chain[DIGIT];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: one DIGIT-wide slice per clock, LSB digit first,
// with result and flags registered and held after the done pulse.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a_ns,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NDIG - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] dig_s;
  logic             dig_c;
  logic [WIDTH-1:0] full_sum;
  logic             a_msb;
  logic             b_msb;
  logic             s_msb;
  logic             ovf_next;

  assign dig_a = a_q[idx*DIGIT +: DIGIT];
  assign dig_b = b_q[idx*DIGIT +: DIGIT];

  addsub_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .c_in (carry_q),
    .a_ns (mode_q),
    .s    (dig_s),
    .c_out(dig_c)
  );

  // Result as it will look once the top digit lands; only meaningful on the last digit.
  assign full_sum = {dig_s, s[WIDTH-DIGIT-1:0]};
  assign a_msb    = a_q[WIDTH-1];
  assign b_msb    = b_q[WIDTH-1];
  assign s_msb    = dig_s[DIGIT-1];
  assign ovf_next = (mode_q == MODE_ADD) ? ((a_msb == b_msb) && (s_msb != a_msb))
                                         : ((a_msb != b_msb) && (s_msb != a_msb));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            mode_q  <= a_ns;
            carry_q <= cin;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          s[idx*DIGIT +: DIGIT] <= dig_s;
          carry_q               <= dig_c;
          if (idx == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= dig_c;
            ovf   <= ovf_next;
            zero  <= (full_sum == '0);
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
